imem_port_arbiter: RTL and testbench
====================================

IMEM_PORT_ARBITER -- requirements
Module: imem_port_arbiter

Interface
REQ-001 Parameter: ADDR_W, 10, instruction memory word-address width (1024 words).
REQ-002 Parameter: DATA_W, 32, instruction word width.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, synchronous and active-high.
REQ-005 Port: f_req  input  1  fetch requester (core PC path) read request.
REQ-006 Port: f_addr  input  32  fetch byte address.
REQ-007 Port: f_gnt  output  1  fetch request accepted this cycle.
REQ-008 Port: f_rvalid  output  1  fetch read data valid.
REQ-009 Port: f_rdata  output  DATA_W  fetch read data.
REQ-010 Port: l_req  input  1  loader requester (program/accelerator-microcode loader) request.
REQ-011 Port: l_we  input  1  loader write enable, qualified by l_req.
REQ-012 Port: l_lock  input  1  loader holds grant for back-to-back burst.
REQ-013 Port: l_addr  input  32  loader byte address.
REQ-014 Port: l_wdata  input  DATA_W  loader write data.
REQ-015 Port: l_gnt  output  1  loader request accepted this cycle.
REQ-016 Port: l_rvalid  output  1  loader read data valid (reads only).
REQ-017 Port: l_rdata  output  DATA_W  loader read data.
REQ-018 Port: err  output  1  one-cycle pulse: accepted request had out-of-range address.
REQ-019 Port: mem_en, mem_we  output  1 each  memory port enable / write enable.
REQ-020 Port: mem_addr  output  ADDR_W  word address = granted addr[ADDR_W+1:2].
REQ-021 Port: mem_wdata  output  DATA_W  write data; mem_rdata  input  DATA_W  read data, 1-cycle synchronous latency.

Function
REQ-022 Block SHALL grant at most one requester per cycle; f_gnt and l_gnt combinational from current requests and state, never both high.
REQ-023 Arbitration states SHALL be FREE and LOCKED; FREE->LOCKED when loader granted with l_lock=1; LOCKED->FREE when l_req=0 or l_lock=0.
REQ-024 In LOCKED, loader SHALL win every cycle it requests; fetch SHALL receive no grant.
REQ-025 In FREE with single requester, that requester SHALL be granted the same cycle.
REQ-026 Contention policy in FREE SHALL follow REQ-038/REQ-039.
REQ-027 Granted in-range request SHALL drive mem_en=1, mem_we=(loader and l_we), mem_addr, mem_wdata the same cycle.
REQ-028 Address in range iff addr[31:ADDR_W+2]==0 and addr[1:0]==0; out-of-range request SHALL still be granted, SHALL NOT assert mem_en, and SHALL pulse err the following cycle.
REQ-029 Granted read SHALL produce rvalid to its owner exactly one cycle after grant with rdata=mem_rdata; out-of-range read SHALL return rvalid with rdata=0.
REQ-030 Writes SHALL produce no rvalid; write followed immediately by read of same address SHALL return written data (memory write-first ordering, passed through).
REQ-031 rdata outputs SHALL hold last value when rvalid=0.
REQ-032 Fully pipelined: one accepted request per cycle sustained, no bubbles between back-to-back grants.

Reset
REQ-033 While rst=1, f_gnt, l_gnt, mem_en, mem_we SHALL be 0 and no request accepted.
REQ-034 On clock edge with rst=1: f_rvalid=0, l_rvalid=0, err=0, f_rdata=0, l_rdata=0, state=FREE, last-winner pointer=loader.
REQ-035 Request granted in the cycle before rst asserts SHALL NOT produce rvalid or err after reset.
REQ-036 Outputs after rst deassertion SHALL depend only on inputs from that cycle onward.

Configuration
REQ-037 Macro IMEM_ARB_RR_EN selects contention policy in FREE.
REQ-038 Defined: round-robin; on simultaneous requests, requester not granted last wins; pointer updates on every grant.
REQ-039 Undefined: fixed priority, fetch always wins in FREE; pointer logic absent.

Verification
REQ-040 rst=1 3 cycles with f_req=l_req=1 -> no gnt, mem_en=0; after release first contention grant goes to fetch under both configurations.
REQ-041 Fetch reads 0x0,0x4,0x8 back-to-back with mem model preloaded 0x001000AB,0x001000AB,0x002030AB -> f_rvalid 3 consecutive cycles, data in order, one cycle after each grant.
REQ-042 Loader l_lock=1 writes 4 words at 0x40..0x4C while f_req=1 -> 4 consecutive l_gnt, f_gnt=0; fetch granted cycle after l_lock drops; fetch of 0x40 returns written word.
REQ-043 Both request continuously 6 cycles, l_lock=0 -> with IMEM_ARB_RR_EN grants alternate F,L,F,L,F,L; without it fetch granted all 6.
REQ-044 Fetch read at 0x1000 and at 0x2 -> granted, mem_en=0, err pulses next cycle, f_rvalid=1 with f_rdata=0.
REQ-045 rst asserted the cycle after a loader read grant -> l_rvalid stays 0, state FREE.

Source files
------------

// File: rtl/imem_port_arbiter_if.sv
// Bus bundle between the instruction-memory port arbiter, its two requesters
// (fetch and loader) and the single-ported instruction memory.
// slave  : arbiter side
// master : requester / memory side
interface imem_port_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  // Fetch requester
  logic              f_req;
  logic [31:0]       f_addr;
  logic              f_gnt;
  logic              f_rvalid;
  logic [DATA_W-1:0] f_rdata;
  // Loader requester
  logic              l_req;
  logic              l_we;
  logic              l_lock;
  logic [31:0]       l_addr;
  logic [DATA_W-1:0] l_wdata;
  logic              l_gnt;
  logic              l_rvalid;
  logic [DATA_W-1:0] l_rdata;
  // Status
  logic              err;
  // Memory port
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  f_req, f_addr,
    input  l_req, l_we, l_lock, l_addr, l_wdata,
    input  mem_rdata,
    output f_gnt, f_rvalid, f_rdata,
    output l_gnt, l_rvalid, l_rdata,
    output err,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output f_req, f_addr,
    output l_req, l_we, l_lock, l_addr, l_wdata,
    output mem_rdata,
    input  f_gnt, f_rvalid, f_rdata,
    input  l_gnt, l_rvalid, l_rdata,
    input  err,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_port_arbiter.sv
// Instruction-memory port arbiter: shares one synchronous memory port between
// the core fetch path and a program/microcode loader. One grant per cycle,
// fully pipelined, loader may lock the port for bursts.
// Optional feature macro: IMEM_ARB_RR_EN (round-robin on contention instead
// of fixed fetch priority).
module imem_port_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input logic                 clk,
  input logic                 rst,
  imem_port_arbiter_if.slave  bus
);

  typedef enum logic {
    ST_FREE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_f_gnt;
  logic              w_l_gnt;
  logic              w_gnt;
  logic              w_write;
  logic [31:0]       w_addr;
  logic              w_in_range;
  logic              w_f_rvalid;
  logic              w_l_rvalid;
  logic [DATA_W-1:0] w_rdata;

  logic              r_f_pend;
  logic              r_l_pend;
  logic              r_oor;
  logic              r_err;
  logic [DATA_W-1:0] r_f_hold;
  logic [DATA_W-1:0] r_l_hold;

`ifdef IMEM_ARB_RR_EN
  logic              r_last_l;   // 1: loader won the most recent grant
`endif

  // Grant decision and lock state transition
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave a value unassigned and infer a latch.
    w_f_gnt     = 1'b0;
    w_l_gnt     = 1'b0;
    w_state_nxt = r_state;
    if (!rst) begin
      case (r_state)
        ST_LOCKED: begin
          w_l_gnt = bus.l_req;
          if (!bus.l_req || !bus.l_lock) w_state_nxt = ST_FREE;
        end
        default: begin
          if (bus.f_req && bus.l_req) begin
`ifdef IMEM_ARB_RR_EN
            w_f_gnt = r_last_l;
            w_l_gnt = !r_last_l;
`else
            w_f_gnt = 1'b1;
`endif
          end else begin
            w_f_gnt = bus.f_req;
            w_l_gnt = bus.l_req;
          end
          if (w_l_gnt && bus.l_lock) w_state_nxt = ST_LOCKED;
        end
      endcase
    end
  end

  assign w_gnt      = w_f_gnt | w_l_gnt;
  assign w_write    = w_l_gnt & bus.l_we;
  assign w_addr     = w_l_gnt ? bus.l_addr : bus.f_addr;
  assign w_in_range = (w_addr[31:ADDR_W+2] == '0) && (w_addr[1:0] == 2'b00);

  assign bus.f_gnt     = w_f_gnt;
  assign bus.l_gnt     = w_l_gnt;
  assign bus.mem_en    = w_gnt & w_in_range;
  assign bus.mem_we    = w_write & w_in_range;
  assign bus.mem_addr  = w_addr[ADDR_W+1:2];
  assign bus.mem_wdata = bus.l_wdata;

  // Responses are gated by rst as well, so a grant taken just before reset
  // never surfaces while reset is asserted.
  assign w_rdata      = r_oor ? '0 : bus.mem_rdata;
  assign w_f_rvalid   = r_f_pend & ~rst;
  assign w_l_rvalid   = r_l_pend & ~rst;
  assign bus.f_rvalid = w_f_rvalid;
  assign bus.l_rvalid = w_l_rvalid;
  assign bus.f_rdata  = w_f_rvalid ? w_rdata : r_f_hold;
  assign bus.l_rdata  = w_l_rvalid ? w_rdata : r_l_hold;
  assign bus.err      = r_err & ~rst;

  // Lock state, response pipeline and read-data hold registers
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (rst) begin
      r_state  <= ST_FREE;
      r_f_pend <= 1'b0;
      r_l_pend <= 1'b0;
      r_oor    <= 1'b0;
      r_err    <= 1'b0;
      r_f_hold <= '0;
      r_l_hold <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_f_pend <= w_f_gnt;
      r_l_pend <= w_l_gnt & ~bus.l_we;
      r_oor    <= ~w_in_range;
      r_err    <= w_gnt & ~w_in_range;
      if (w_f_rvalid) r_f_hold <= w_rdata;
      if (w_l_rvalid) r_l_hold <= w_rdata;
    end
  end

`ifdef IMEM_ARB_RR_EN
  // Last-winner pointer, refreshed on every grant
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_l <= 1'b1;
    end else if (w_l_gnt) begin
      r_last_l <= 1'b1;
    end else if (w_f_gnt) begin
      r_last_l <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Self-checking bench for imem_port_arbiter: directed scenarios followed by
// randomized traffic, scored against a transaction-level reference model.
module tb_imem_port_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;
`ifdef IMEM_ARB_RR_EN
  localparam bit RR_MODE = 1'b1;
`else
  localparam bit RR_MODE = 1'b0;
`endif

  typedef struct {
    int unsigned cyc;
    logic [31:0] data;
  } resp_t;

  logic clk;
  logic rst;

  imem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  imem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int          total = 0;
  int          bad   = 0;
  int unsigned cyc   = 0;

  resp_t       exp_f_q[$];
  resp_t       exp_l_q[$];
  int unsigned exp_err_q[$];

  logic [31:0] ref_mem [1024];
  logic [31:0] tb_mem  [1024];
  bit          loaded = 1'b0;

  bit          m_locked = 1'b0;
  bit          m_last_l = 1'b1;
  logic [31:0] last_f = '0;
  logic [31:0] last_l = '0;
  bit          last_fg;
  bit          last_lg;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    if (i < 2)  return 32'h0010_00AB;
    if (i == 2) return 32'h0020_30AB;
    return (i * 32'h9E37_79B1) ^ 32'h0000_5A5A;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Synchronous write-first memory attached to the arbiter's port
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 1024; i++) tb_mem[i] <= init_word(i);
      loaded <= 1'b1;
    end else if (bus.mem_en) begin
      if (bus.mem_we) begin
        tb_mem[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata        <= bus.mem_wdata;
      end else begin
        bus.mem_rdata <= tb_mem[bus.mem_addr];
      end
    end
  end

  // Response monitor: pops the scoreboard whenever the DUT presents a response
  always @(negedge clk) begin
    resp_t       e;
    int unsigned ec;
    if (rst) begin
      check("rst_f_rvalid", bus.f_rvalid, 0);
      check("rst_l_rvalid", bus.l_rvalid, 0);
      check("rst_err", bus.err, 0);
      last_f = '0;
      last_l = '0;
    end else begin
      if (bus.f_rvalid) begin
        if (exp_f_q.size() == 0) check("f_rvalid_unexpected", bus.f_rvalid, 0);
        else begin
          e = exp_f_q.pop_front();
          check("f_rvalid_cycle", cyc, e.cyc);
          check("f_rdata", bus.f_rdata, e.data);
          last_f = e.data;
        end
      end else begin
        check("f_rdata_hold", bus.f_rdata, last_f);
      end
      if (bus.l_rvalid) begin
        if (exp_l_q.size() == 0) check("l_rvalid_unexpected", bus.l_rvalid, 0);
        else begin
          e = exp_l_q.pop_front();
          check("l_rvalid_cycle", cyc, e.cyc);
          check("l_rdata", bus.l_rdata, e.data);
          last_l = e.data;
        end
      end else begin
        check("l_rdata_hold", bus.l_rdata, last_l);
      end
      if (bus.err) begin
        if (exp_err_q.size() == 0) check("err_unexpected", bus.err, 0);
        else begin
          ec = exp_err_q.pop_front();
          check("err_cycle", cyc, ec);
        end
      end
    end
  end

  // One cycle of stimulus: drive, predict, score the combinational outputs,
  // queue the expected responses, then advance the model across the edge.
  task automatic step(input bit r, input bit fr, input logic [31:0] fa,
                      input bit lr, input bit lw, input bit ll,
                      input logic [31:0] la, input logic [31:0] wd);
    bit          ef, el, inr, gnt, wr;
    logic [31:0] a;
    logic [AW-1:0] idx;
    resp_t       e;
    rst         = r;
    bus.f_req   = fr;
    bus.f_addr  = fa;
    bus.l_req   = lr;
    bus.l_we    = lw;
    bus.l_lock  = ll;
    bus.l_addr  = la;
    bus.l_wdata = wd;
    #1;
    if (r) begin
      exp_f_q.delete();
      exp_l_q.delete();
      exp_err_q.delete();
      ef = 1'b0;
      el = 1'b0;
    end else if (m_locked) begin
      ef = 1'b0;
      el = lr;
    end else if (fr && lr) begin
      ef = RR_MODE ? !m_last_l : 1'b1;
      el = !ef;
    end else begin
      ef = fr;
      el = lr;
    end
    a   = el ? la : fa;
    inr = ((a >> (AW + 2)) == 0) && (a[1:0] == 2'b00);
    gnt = ef | el;
    wr  = el & lw;
    idx = a[AW+1:2];
    check("f_gnt", bus.f_gnt, ef);
    check("l_gnt", bus.l_gnt, el);
    check("mem_en", bus.mem_en, gnt && inr);
    check("mem_we", bus.mem_we, wr && inr);
    if (gnt && inr) check("mem_addr", bus.mem_addr, idx);
    if (wr && inr) check("mem_wdata", bus.mem_wdata, wd);
    if (gnt && !inr) exp_err_q.push_back(cyc + 1);
    if (gnt && !wr) begin
      e.cyc  = cyc + 1;
      e.data = inr ? ref_mem[idx] : 32'h0;
      if (ef) exp_f_q.push_back(e);
      else    exp_l_q.push_back(e);
    end
    if (wr && inr) ref_mem[idx] = wd;
    last_fg = bus.f_gnt;
    last_lg = bus.l_gnt;
    @(posedge clk);
    cyc++;
    if (r) begin
      m_locked = 1'b0;
      m_last_l = 1'b1;
    end else begin
      if (m_locked) begin
        if (!lr || !ll) m_locked = 1'b0;
      end else if (el && ll) begin
        m_locked = 1'b1;
      end
      if (el)      m_last_l = 1'b1;
      else if (ef) m_last_l = 1'b0;
    end
    #1;
  endtask

  task automatic idle();
    step(0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0);
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned k;
    logic [31:0] w;
    k = $urandom_range(0, 19);
    w = 32'($urandom_range(0, 15)) << 2;
    if (k == 0) return 32'h0000_1000 | w;
    if (k == 1) return w | 32'($urandom_range(1, 3));
    if (k == 2) return 32'h8000_0000 | w;
    return w;
  endfunction

  initial begin
    int          lg_cnt, fg_cnt;
    logic [5:0]  pat;
    logic [5:0]  pat_exp;
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
    rst = 1'b1;
    bus.f_req = 1'b0; bus.f_addr = '0;
    bus.l_req = 1'b0; bus.l_we = 1'b0; bus.l_lock = 1'b0;
    bus.l_addr = '0; bus.l_wdata = '0;
    @(posedge clk);
    #1;

    // Reset held with both requesting, then continuous contention
    for (int i = 0; i < 3; i++) step(1, 1, 32'h100, 1, 0, 0, 32'h104, 32'h0);
    pat = '0;
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 32'h100 + 32'(i * 8), 1, 0, 0, 32'h104 + 32'(i * 8), 32'h0);
      pat[i] = last_fg;
    end
    check("first_contention_fetch", pat[0], 1);
    pat_exp = RR_MODE ? 6'b010101 : 6'b111111;
    check("contention_pattern", pat, pat_exp);

    // Back-to-back fetch reads of preloaded words
    step(0, 1, 32'h0, 0, 0, 0, 32'h0, 32'h0);
    step(0, 1, 32'h4, 0, 0, 0, 32'h0, 32'h0);
    step(0, 1, 32'h8, 0, 0, 0, 32'h0, 32'h0);
    idle();

    // Locked loader burst while fetch keeps requesting
    lg_cnt = 0; fg_cnt = 0;
    step(0, 0, 32'h200, 1, 1, 1, 32'h40, 32'hCAFE_0040);
    lg_cnt += int'(last_lg); fg_cnt += int'(last_fg);
    step(0, 1, 32'h200, 1, 1, 1, 32'h44, 32'hCAFE_0044);
    lg_cnt += int'(last_lg); fg_cnt += int'(last_fg);
    step(0, 1, 32'h200, 1, 1, 1, 32'h48, 32'hCAFE_0048);
    lg_cnt += int'(last_lg); fg_cnt += int'(last_fg);
    step(0, 1, 32'h200, 1, 1, 0, 32'h4C, 32'hCAFE_004C);
    lg_cnt += int'(last_lg); fg_cnt += int'(last_fg);
    check("burst_l_gnt_count", lg_cnt, 4);
    check("burst_f_gnt_count", fg_cnt, 0);
    step(0, 1, 32'h40, 0, 0, 0, 32'h0, 32'h0);
    check("fetch_after_unlock", last_fg, 1);
    idle();

    // Out-of-range fetches, plus an out-of-range loader write
    step(0, 1, 32'h1000, 0, 0, 0, 32'h0, 32'h0);
    step(0, 1, 32'h2, 0, 0, 0, 32'h0, 32'h0);
    idle();
    step(0, 0, 32'h0, 1, 1, 0, 32'h41, 32'hDEAD_BEEF);
    idle();

    // Reset right after a locked loader read grant
    step(0, 0, 32'h0, 1, 0, 1, 32'h8, 32'h0);
    step(1, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0);
    step(0, 1, 32'h4, 0, 0, 0, 32'h0, 32'h0);
    check("fetch_after_rst_free", last_fg, 1);
    idle();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 59) == 0,
           1'($urandom), rand_addr(),
           1'($urandom), 1'($urandom), 1'($urandom), rand_addr(), $urandom);
    end

    for (int i = 0; i < 3; i++) idle();
    check("f_queue_drained", exp_f_q.size(), 0);
    check("l_queue_drained", exp_l_q.size(), 0);
    check("err_queue_drained", exp_err_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
